// File: rtl/conv_weights_load_scheduler_if.sv
// DDR reader and weight-buffer write-side signals of the convolution weight load scheduler.
interface conv_weights_load_scheduler_if #(
    parameter int WORD_W = 512,
    parameter int ADR_W  = 16,
    parameter int CNT_W  = 16
);
    logic              ddr_req_valid;
    logic              ddr_req_ready;
    logic [CNT_W-1:0]  ddr_req_tile;
    logic              ddr_data_valid;
    logic [WORD_W-1:0] ddr_data;
    logic              ddr_data_ready;
    logic              weights_word_buf_en_wt;
    logic [ADR_W-1:0]  weights_word_buf_adr_wt;
    logic [WORD_W-1:0] weights_word_buf_wt;

    modport master (
        output ddr_req_valid,
        output ddr_req_tile,
        output ddr_data_ready,
        output weights_word_buf_en_wt,
        output weights_word_buf_adr_wt,
        output weights_word_buf_wt,
        input  ddr_req_ready,
        input  ddr_data_valid,
        input  ddr_data
    );

    modport slave (
        input  ddr_req_valid,
        input  ddr_req_tile,
        input  ddr_data_ready,
        input  weights_word_buf_en_wt,
        input  weights_word_buf_adr_wt,
        input  weights_word_buf_wt,
        output ddr_req_ready,
        output ddr_data_valid,
        output ddr_data
    );
endinterface

// File: rtl/conv_weights_load_scheduler.sv
// Tile-by-tile weight loader: fetch from DDR, fill the write side, swap once compute releases the read side.
// Optional CONV_WEIGHTS_SCHED_PERF_EN adds WAIT and compute-starvation cycle counters.
module conv_weights_load_scheduler #(
    parameter int WORD_W = 512,
    parameter int ADR_W  = 16,
    parameter int CNT_W  = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start_i,
    input  logic [CNT_W-1:0]                num_tiles_i,
    input  logic [CNT_W-1:0]                words_per_tile_i,
    conv_weights_load_scheduler_if.master   ddr_bus,
    output logic                            conv_load_weights_o,
    output logic                            comp_tile_valid_o,
    input  logic                            comp_tile_done_i,
    output logic                            busy_o,
`ifdef CONV_WEIGHTS_SCHED_PERF_EN
    output logic                            done_o,
    output logic [31:0]                     perf_wait_cycles_o,
    output logic [31:0]                     perf_starve_cycles_o
`else
    output logic                            done_o
`endif
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_FILL  = 3'd2,
        S_WAIT  = 3'd3,
        S_SWAP  = 3'd4,
        S_DRAIN = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] num_tiles_q, num_tiles_d;
    logic [CNT_W-1:0] words_q, words_d;
    logic [CNT_W-1:0] fill_tile_q, fill_tile_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0] req_tile_q, req_tile_d;
    logic             req_valid_q, req_valid_d;
    logic             swap_q, swap_d;
    logic             comp_busy_q, comp_busy_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             beat_s;
    logic             start_ok_s;

    assign beat_s     = (state_q == S_FILL) && ddr_bus.ddr_data_valid;
    assign start_ok_s = start_i && (state_q == S_IDLE);

    // Next-state and registered-output decode.
    always_comb begin
        state_d     = state_q;
        num_tiles_d = num_tiles_q;
        words_d     = words_q;
        fill_tile_d = fill_tile_q;
        word_cnt_d  = word_cnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_ok_s) begin
                    num_tiles_d = num_tiles_i;
                    words_d     = words_per_tile_i;
                    fill_tile_d = {CNT_W{1'b0}};
                    word_cnt_d  = {CNT_W{1'b0}};
                    if (num_tiles_i == {CNT_W{1'b0}}) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_REQ;
                        busy_d  = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                if (ddr_bus.ddr_req_ready) begin
                    state_d    = S_FILL;
                    word_cnt_d = {CNT_W{1'b0}};
                end else begin
                    state_d = S_REQ;
                end
            end
            S_FILL: begin
                if (beat_s) begin
                    word_cnt_d = word_cnt_q + CNT_W'(1);
                    if (word_cnt_q == (words_q - CNT_W'(1))) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_FILL;
                    end
                end else begin
                    state_d = S_FILL;
                end
            end
            S_WAIT: begin
                if (!comp_busy_q || comp_tile_done_i) begin
                    state_d = S_SWAP;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_SWAP: begin
                fill_tile_d = fill_tile_q + CNT_W'(1);
                if ((fill_tile_q + CNT_W'(1)) < num_tiles_q) begin
                    state_d = S_REQ;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // A done pulse with compute idle is not the release of the final tile.
                if (comp_tile_done_i && comp_busy_q) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        req_valid_d = (state_d == S_REQ);
        req_tile_d  = fill_tile_d;
        swap_d      = (state_d == S_SWAP);
        if (state_d == S_SWAP) begin
            comp_busy_d = 1'b1;
        end else if (comp_tile_done_i) begin
            comp_busy_d = 1'b0;
        end else begin
            comp_busy_d = comp_busy_q;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            num_tiles_q <= {CNT_W{1'b0}};
            words_q     <= {CNT_W{1'b0}};
            fill_tile_q <= {CNT_W{1'b0}};
            word_cnt_q  <= {CNT_W{1'b0}};
            req_tile_q  <= {CNT_W{1'b0}};
            req_valid_q <= 1'b0;
            swap_q      <= 1'b0;
            comp_busy_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            num_tiles_q <= num_tiles_d;
            words_q     <= words_d;
            fill_tile_q <= fill_tile_d;
            word_cnt_q  <= word_cnt_d;
            req_tile_q  <= req_tile_d;
            req_valid_q <= req_valid_d;
            swap_q      <= swap_d;
            comp_busy_q <= comp_busy_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign ddr_bus.ddr_req_valid           = req_valid_q;
    assign ddr_bus.ddr_req_tile            = req_tile_q;
    assign ddr_bus.ddr_data_ready          = (state_q == S_FILL);
    assign ddr_bus.weights_word_buf_en_wt  = beat_s;
    assign ddr_bus.weights_word_buf_adr_wt = ADR_W'(word_cnt_q);
    // Write data is gated so the buffer port stays quiet outside accepted beats.
    assign ddr_bus.weights_word_buf_wt     = beat_s ? ddr_bus.ddr_data : {WORD_W{1'b0}};
    assign conv_load_weights_o             = swap_q;
    assign comp_tile_valid_o               = comp_busy_q;
    assign busy_o                          = busy_q;
    assign done_o                          = done_q;

`ifdef CONV_WEIGHTS_SCHED_PERF_EN
    logic [31:0] perf_wait_q, perf_wait_d;
    logic [31:0] perf_starve_q, perf_starve_d;

    // Saturating counters, cleared when a layer is accepted.
    always_comb begin
        perf_wait_d   = perf_wait_q;
        perf_starve_d = perf_starve_q;
        if (start_ok_s) begin
            perf_wait_d   = 32'd0;
            perf_starve_d = 32'd0;
        end else begin
            if ((state_q == S_WAIT) && (perf_wait_q != 32'hFFFF_FFFF)) begin
                perf_wait_d = perf_wait_q + 32'd1;
            end else begin
                perf_wait_d = perf_wait_q;
            end
            if (busy_q && !comp_busy_q && (state_q != S_SWAP) && (perf_starve_q != 32'hFFFF_FFFF)) begin
                perf_starve_d = perf_starve_q + 32'd1;
            end else begin
                perf_starve_d = perf_starve_q;
            end
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_wait_q   <= 32'd0;
            perf_starve_q <= 32'd0;
        end else begin
            perf_wait_q   <= perf_wait_d;
            perf_starve_q <= perf_starve_d;
        end
    end

    assign perf_wait_cycles_o   = perf_wait_q;
    assign perf_starve_cycles_o = perf_starve_q;
`endif

endmodule

// File: tb/tb_conv_weights_load_scheduler.sv
// Randomized cycle-level bench: a transaction-count model of fetch/fill/swap/drain predicts every output.
module tb_conv_weights_load_scheduler;
    localparam int WORD_W = 512;
    localparam int ADR_W  = 16;
    localparam int CNT_W  = 16;

    logic              clk;
    logic              reset;
    logic              start_i;
    logic [CNT_W-1:0]  num_tiles_i;
    logic [CNT_W-1:0]  words_per_tile_i;
    logic              conv_load_weights_o;
    logic              comp_tile_valid_o;
    logic              comp_tile_done_i;
    logic              busy_o;
    logic              done_o;
`ifdef CONV_WEIGHTS_SCHED_PERF_EN
    logic [31:0]       perf_wait_cycles_o;
    logic [31:0]       perf_starve_cycles_o;
`endif

    conv_weights_load_scheduler_if #(.WORD_W(WORD_W), .ADR_W(ADR_W), .CNT_W(CNT_W)) bus_if ();

    conv_weights_load_scheduler #(.WORD_W(WORD_W), .ADR_W(ADR_W), .CNT_W(CNT_W)) dut (
        .clk                 (clk),
        .reset               (reset),
        .start_i             (start_i),
        .num_tiles_i         (num_tiles_i),
        .words_per_tile_i    (words_per_tile_i),
        .ddr_bus             (bus_if),
        .conv_load_weights_o (conv_load_weights_o),
        .comp_tile_valid_o   (comp_tile_valid_o),
        .comp_tile_done_i    (comp_tile_done_i),
        .busy_o              (busy_o),
`ifdef CONV_WEIGHTS_SCHED_PERF_EN
        .done_o              (done_o),
        .perf_wait_cycles_o  (perf_wait_cycles_o),
        .perf_starve_cycles_o(perf_starve_cycles_o)
`else
        .done_o              (done_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass;
    int n_checks;
    // model of the layer in flight, counted in transactions
    int m_n, m_w, m_hs, m_beats, m_swaps, hold;
    bit m_busy, m_req_pending, m_comp_busy, m_swap_next, m_done_next;
    int m_pw, m_ps;
    // stimulus knobs
    int rp, vp, hlo, hhi;
    bit dv_toggle, tog;
    int obs_swaps, obs_writes, obs_done, obs_hs;

    function automatic logic [511:0] gen(input int k);
        logic [511:0] g;
        for (int i = 0; i < 16; i++) begin
            g[i*32 +: 32] = (k * 32'h9E37_79B1) ^ (i * 32'h0101_0101) ^ 32'h5A5A_0000;
        end
        return g;
    endfunction

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_clear();
        m_n = 0; m_w = 0; m_hs = 0; m_beats = 0; m_swaps = 0; hold = 0;
        m_busy = 1'b0; m_req_pending = 1'b0; m_comp_busy = 1'b0;
        m_swap_next = 1'b0; m_done_next = 1'b0; m_pw = 0; m_ps = 0;
    endtask

    task automatic set_cfg(input int r, input int v, input int lo, input int hi, input bit tg);
        rp = r; vp = v; hlo = lo; hhi = hi; dv_toggle = tg; tog = 1'b1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_req_valid"}, 512'(bus_if.ddr_req_valid), 512'(0));
        check({tag, "_req_tile"}, 512'(bus_if.ddr_req_tile), 512'(0));
        check({tag, "_data_ready"}, 512'(bus_if.ddr_data_ready), 512'(0));
        check({tag, "_en_wt"}, 512'(bus_if.weights_word_buf_en_wt), 512'(0));
        check({tag, "_adr_wt"}, 512'(bus_if.weights_word_buf_adr_wt), 512'(0));
        check({tag, "_wt"}, bus_if.weights_word_buf_wt, 512'(0));
        check({tag, "_swap"}, 512'(conv_load_weights_o), 512'(0));
        check({tag, "_comp_valid"}, 512'(comp_tile_valid_o), 512'(0));
        check({tag, "_busy"}, 512'(busy_o), 512'(0));
        check({tag, "_done"}, 512'(done_o), 512'(0));
`ifdef CONV_WEIGHTS_SCHED_PERF_EN
        check({tag, "_perf_wait"}, 512'(perf_wait_cycles_o), 512'(0));
        check({tag, "_perf_starve"}, 512'(perf_starve_cycles_o), 512'(0));
`endif
    endtask

    // One clock: drive inputs at the falling edge, check outputs 1 ns later, then advance the model.
    task automatic do_cycle(input bit st, input int n, input int w);
        bit rdy, dv, cd, exp_rdy, in_wait, hs_now, beat_now, swap_dec, done_dec, acc;
        @(negedge clk);
        rdy = ($urandom_range(99, 0) < rp);
        if (dv_toggle) begin
            dv = tog; tog = !tog;
        end else begin
            dv = ($urandom_range(99, 0) < vp);
        end
        if (m_swap_next) begin
            hold = int'($urandom_range(hhi, hlo)); cd = 1'b0;
        end else if (m_comp_busy) begin
            hold = hold - 1; cd = (hold <= 0);
        end else begin
            cd = ($urandom_range(99, 0) < 3);
        end
        start_i = st;
        num_tiles_i = 16'(n);
        words_per_tile_i = 16'(w);
        bus_if.ddr_req_ready = rdy;
        bus_if.ddr_data_valid = dv;
        bus_if.ddr_data = gen(m_beats);
        comp_tile_done_i = cd;
        #1;
        exp_rdy = m_busy && (m_beats < m_hs * m_w);
        in_wait = m_busy && (m_hs == m_swaps + 1) && (m_beats == m_hs * m_w);
        check("req_valid", 512'(bus_if.ddr_req_valid), 512'(m_req_pending));
        if (m_req_pending) check("req_tile", 512'(bus_if.ddr_req_tile), 512'(m_hs));
        check("data_ready", 512'(bus_if.ddr_data_ready), 512'(exp_rdy));
        check("en_wt", 512'(bus_if.weights_word_buf_en_wt), 512'(exp_rdy && dv));
        if (exp_rdy && dv) begin
            check("adr_wt", 512'(bus_if.weights_word_buf_adr_wt), 512'(m_beats - (m_hs - 1) * m_w));
            check("wt", bus_if.weights_word_buf_wt, gen(m_beats));
        end
        check("swap", 512'(conv_load_weights_o), 512'(m_swap_next));
        check("comp_valid", 512'(comp_tile_valid_o), 512'(m_comp_busy));
        check("busy", 512'(busy_o), 512'(m_busy));
        check("done", 512'(done_o), 512'(m_done_next));
        obs_swaps  += int'(conv_load_weights_o === 1'b1);
        obs_writes += int'(bus_if.weights_word_buf_en_wt === 1'b1);
        obs_done   += int'(done_o === 1'b1);
        obs_hs     += int'((bus_if.ddr_req_valid === 1'b1) && rdy);

        hs_now   = m_req_pending && rdy;
        beat_now = exp_rdy && dv;
        swap_dec = in_wait && (!m_comp_busy || cd);
        done_dec = m_busy && (m_swaps == m_n) && !m_swap_next && m_comp_busy && cd;
        acc      = st && !m_busy;
        m_pw += int'(in_wait);
        m_ps += int'(m_busy && !m_comp_busy && !m_swap_next);
        if (hs_now) m_req_pending = 1'b0;
        else if (m_swap_next && (m_swaps < m_n)) m_req_pending = 1'b1;
        m_hs += int'(hs_now);
        m_beats += int'(beat_now);
        m_swap_next = swap_dec;
        if (swap_dec) m_swaps++;
        m_comp_busy = swap_dec ? 1'b1 : (cd ? 1'b0 : m_comp_busy);
        m_done_next = done_dec;
        if (done_dec) m_busy = 1'b0;
        if (acc) begin
            m_n = n; m_w = w; m_hs = 0; m_beats = 0; m_swaps = 0; m_pw = 0; m_ps = 0;
            if (n == 0) m_done_next = 1'b1;
            else begin m_busy = 1'b1; m_req_pending = 1'b1; end
        end
    endtask

    task automatic run_layer(input int n, input int w, input bit inject);
        int cnt;
        obs_swaps = 0; obs_writes = 0; obs_done = 0; obs_hs = 0;
        do_cycle(1'b1, n, w);
        cnt = 0;
        while ((m_busy || m_done_next) && cnt < 3000) begin
            do_cycle(inject && m_busy && ($urandom_range(15, 0) == 0),
                     int'($urandom_range(5, 0)), int'($urandom_range(6, 1)));
            cnt++;
        end
        check("layer_timeout", 512'(cnt < 3000), 512'(1));
        check("swap_count", 512'(obs_swaps), 512'(n));
        check("write_count", 512'(obs_writes), 512'(n * w));
        check("req_count", 512'(obs_hs), 512'(n));
        check("done_count", 512'(obs_done), 512'(1));
`ifdef CONV_WEIGHTS_SCHED_PERF_EN
        check("perf_wait", 512'(perf_wait_cycles_o), 512'(m_pw));
        check("perf_starve", 512'(perf_starve_cycles_o), 512'(m_ps));
`endif
    endtask

    initial begin
        n_pass = 0; n_checks = 0;
        start_i = 1'b0; num_tiles_i = '0; words_per_tile_i = '0; comp_tile_done_i = 1'b0;
        bus_if.ddr_req_ready = 1'b0; bus_if.ddr_data_valid = 1'b0; bus_if.ddr_data = '0;
        model_clear();
        set_cfg(100, 100, 5, 5, 1'b0);
        reset = 1'b1;
        #2 reset = 1'b0;
        #1 check_zero("reset");
        repeat (2) @(negedge clk);
        reset = 1'b1;

        run_layer(1, 4, 1'b0);
        set_cfg(100, 100, 20, 20, 1'b0);
        run_layer(3, 2, 1'b0);
        set_cfg(100, 0, 1, 3, 1'b1);
        run_layer(2, 5, 1'b0);
        set_cfg(100, 100, 2, 4, 1'b0);
        run_layer(0, 3, 1'b0);
        set_cfg(60, 70, 2, 8, 1'b0);
        run_layer(2, 3, 1'b1);
        for (int i = 0; i < 6; i++) begin
            set_cfg(int'($urandom_range(100, 30)), int'($urandom_range(100, 30)),
                    1, int'($urandom_range(12, 1)), 1'b0);
            run_layer(int'($urandom_range(4, 1)), int'($urandom_range(6, 1)), 1'b1);
        end

        // abort a layer while words are streaming in
        set_cfg(100, 100, 5, 5, 1'b0);
        do_cycle(1'b1, 2, 8);
        for (int i = 0; i < 50; i++) begin
            if (m_busy && (m_beats >= 2) && (m_beats < m_hs * m_w)) break;
            do_cycle(1'b0, 0, 1);
        end
        check("abort_in_fill", 512'(m_busy && (m_beats >= 2) && (m_beats < m_hs * m_w)), 512'(1));
        bus_if.ddr_data_valid = 1'b1;
        comp_tile_done_i = 1'b0;
        #1 reset = 1'b0;
        #1 check_zero("abort");
        model_clear();
        @(negedge clk);
        check_zero("abort_hold");
        reset = 1'b1;
        run_layer(1, 4, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
